// File: rtl/trace_capture_pkg.sv
// Shared types and default constants for the trace capture block.
package trace_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int TDATA_W        = 64;
  localparam int DEF_DATA_W     = 20;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int TDATA_PAD_W    = TDATA_W - 2 * DEF_DATA_W;

endpackage

// File: rtl/trace_capture_if.sv
// Output sample stream carrying {pad, tri, data} beats.
interface trace_capture_if;
  import trace_capture_pkg::*;

  logic [TDATA_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);

endinterface

// File: rtl/trace_capture_fifo.sv
// Small first-word-fall-through FIFO; a pop frees space for a push in the same cycle.
module trace_capture_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = count_reg[AW];
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/trace_capture.sv
// Logic-analyser style capture: synchronise pins, wait for a masked trigger,
// stream a fixed number of {tri, data} samples out through a small FIFO.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] pin_data_i,
  input  logic [DATA_W-1:0] pin_tri_i,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  sample_count,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  trace_capture_if.master   m_axis,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  captured,
  output logic [2:0]        state
);

  localparam int PAD_W = TDATA_W - 2 * DATA_W;

  state_t                      state_reg;
  logic [DATA_W-1:0]           sync1_reg;
  logic [DATA_W-1:0]           sync2_reg;
  logic [DATA_W-1:0]           trig_mask_reg;
  logic [DATA_W-1:0]           trig_value_reg;
  logic [CNT_W-1:0]            sample_count_reg;
  logic [CNT_W-1:0]            captured_reg;
  logic                        overflow_reg;

  logic [DATA_W-1:0]           bit_match;
  logic                        trig_hit;
  logic [CNT_W-1:0]            captured_inc;
  logic                        sampling;
  logic                        room;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [2*DATA_W-1:0]         fifo_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pin_data_i;
      sync2_reg <= sync1_reg;
    end
  end

  // Masked-off bits always match, so a zero mask fires immediately.
  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_match
    assign bit_match[gi] = !trig_mask_reg[gi] || (sync2_reg[gi] == trig_value_reg[gi]);
  end
  assign trig_hit = &bit_match;

  assign captured_inc = (captured_reg == '1) ? captured_reg : captured_reg + 1'b1;
  assign sampling     = !stop && ((state_reg == ST_CAPTURE) ||
                                  ((state_reg == ST_ARMED) && trig_hit));
  assign fifo_pop     = !fifo_empty && m_axis.m_tready;
  assign room         = !fifo_full || fifo_pop;
  assign fifo_push    = sampling && room;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= ST_IDLE;
      trig_mask_reg    <= '0;
      trig_value_reg   <= '0;
      sample_count_reg <= '0;
      captured_reg     <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start && (sample_count != '0)) begin
            state_reg        <= ST_ARMED;
            trig_mask_reg    <= trig_mask;
            trig_value_reg   <= trig_value;
            sample_count_reg <= sample_count;
            captured_reg     <= '0;
            overflow_reg     <= 1'b0;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (stop) begin
            state_reg <= (state_reg == ST_ARMED) ? ST_IDLE : ST_DRAIN;
          end else if (sampling) begin
            if (!room) begin
              overflow_reg <= 1'b1;
              state_reg    <= ST_DRAIN;
            end else begin
              captured_reg <= captured_inc;
              state_reg    <= (captured_inc == sample_count_reg) ? ST_DRAIN : ST_CAPTURE;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  trace_capture_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data ({pin_tri_i, sync2_reg}),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign m_axis.m_tdata  = {{PAD_W{1'b0}}, fifo_rd};
  assign m_axis.m_tvalid = !fifo_empty;
  // Only the final entry left in DRAIN is the last beat; an empty DRAIN emits none.
  assign m_axis.m_tlast  = (state_reg == ST_DRAIN) &&
                           (fifo_count == {{$clog2(FIFO_DEPTH){1'b0}}, 1'b1});

  assign busy     = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE) ||
                    (state_reg == ST_DRAIN);
  assign done     = (state_reg == ST_DONE);
  assign overflow = overflow_reg;
  assign captured = captured_reg;
  assign state    = state_reg;

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  capture clock (pattern-generator clock domain); resetn  in  1  asynchronous active-low reset.
REQ-002 Parameters SHALL be: DATA_W, 20, pin count; CNT_W, 16, sample-counter width; FIFO_DEPTH, 4, output FIFO entries (power of 2).
REQ-003 pin_data_i  in  DATA_W  raw pin levels from the pin IOBUF outputs, asynchronous to clk.
REQ-004 pin_tri_i  in  DATA_W  per-pin tristate enables (1 = pin is input), synchronous to clk.
REQ-005 start  in  1  single-cycle arm pulse; stop  in  1  single-cycle abort pulse.
REQ-006 sample_count  in  CNT_W  samples per capture, sampled on start; trig_mask, trig_value  in  DATA_W  trigger pattern, sampled on start.
REQ-007 m_tdata  out  64  {24'h0, tri, data}; m_tvalid  out  1; m_tready  in  1; m_tlast  out  1.
REQ-008 busy  out  1; done  out  1; overflow  out  1  sticky; captured  out  CNT_W  samples pushed in the current or last capture; state  out  3  FSM encoding.

Function
REQ-009 pin_data_i SHALL pass through a 2-flop synchronizer; all trigger and sample logic SHALL use the synchronized value (2-cycle latency).
REQ-010 FSM states: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, DONE=4.
REQ-011 IDLE/DONE + start with sample_count != 0 -> ARMED; latch sample_count/trig_*, clear captured, overflow, done; start with sample_count == 0 SHALL be ignored.
REQ-012 ARMED: when (sync_data & trig_mask) == (trig_value & trig_mask) -> CAPTURE; the matching sample SHALL be the first sample pushed; trig_mask == 0 triggers on the first ARMED cycle.
REQ-013 CAPTURE pushes {tri, sync_data} into the FIFO every cycle and increments captured; on the push where captured reaches sample_count -> DRAIN.
REQ-014 FIFO full at a push -> sample dropped, overflow set, captured not incremented, FSM -> DRAIN.
REQ-015 stop in ARMED -> IDLE; stop in CAPTURE -> DRAIN with no further pushes; stop in DRAIN/DONE/IDLE ignored; stop SHALL beat a simultaneous trigger or final push.
REQ-016 DRAIN: -> DONE when FIFO empty; done=1 while in DONE; busy=1 in ARMED, CAPTURE, DRAIN.
REQ-017 m_tvalid = FIFO not empty; pop on m_tvalid && m_tready; m_tdata stable while m_tvalid && !m_tready.
REQ-018 m_tlast = 1 iff state == DRAIN and FIFO holds exactly one entry; if DRAIN is entered with an empty FIFO, no tlast SHALL be emitted (stop with all samples already popped).
REQ-019 Push and pop in the same cycle on a full FIFO SHALL not overflow (pop first).
REQ-020 captured SHALL saturate at 2^CNT_W-1; sample_count compare is unsigned.

Reset
REQ-021 resetn low SHALL asynchronously force: state=IDLE, FIFO empty, m_tvalid=0, m_tlast=0, busy=0, done=0, overflow=0, captured=0, synchronizer flops=0, latched trigger/count registers=0.
REQ-022 Reset mid-capture SHALL discard FIFO contents; no beat SHALL be emitted until the next start.

Structure
REQ-023 A shared package SHALL hold the state enum, the 64-bit tdata pad width and default parameter constants.
REQ-024 The FIFO SHALL be one sub-module, trace_capture_fifo (synchronous, first-word-fall-through, count output).

Verification
REQ-025 sample_count=8, mask=0, m_tready=1 -> 8 beats, tlast on beat 8 only, captured=8, done=1, overflow=0.
REQ-026 mask=20'h00001, value=20'h00001, pin0 rises after 10 cycles -> first beat data[0]=1, preceded by no beats.
REQ-027 sample_count=16, m_tready=0 -> 4 entries held, overflow=1, captured=4; raise m_tready -> 4 beats, tlast on 4th, done=1.
REQ-028 sample_count=100, stop after 20 captured, m_tready=1 -> total beats=20 (±in-flight), tlast on final beat, done=1.
REQ-029 resetn pulsed low while in CAPTURE with FIFO non-empty -> m_tvalid=0 immediately, state=0, no beats until next start.
REQ-030 start with sample_count=0 -> state stays IDLE, busy=0, no beats.
